// File: rtl/perf_event_collector.sv
// Per-event saturating accumulators that drain deltas to the HPM counter block.
// Optional input register stage: define PERF_COLLECT_INREG_EN.
module perf_event_collector #(
    parameter int NrEvents = 32,
    parameter int IncW     = 2,
    parameter int AccW     = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     freeze_i,
    input  logic [NrEvents-1:0]      en_mask_i,
    input  logic [NrEvents*IncW-1:0] inc_i,
    output logic                     delta_valid_o,
    input  logic                     delta_ready_i,
    output logic [NrEvents*AccW-1:0] delta_o,
    output logic [NrEvents-1:0]      ovf_o,
    input  logic                     ovf_clr_i
);

    logic [NrEvents*IncW-1:0] inc_s;
    logic [NrEvents-1:0]      en_s;
    logic                     frz_s;

`ifdef PERF_COLLECT_INREG_EN
    logic [NrEvents*IncW-1:0] inc_d, inc_q;
    logic [NrEvents-1:0]      en_d, en_q;
    logic                     frz_d, frz_q;

    always_comb begin
        inc_d = inc_i;
        en_d  = en_mask_i;
        frz_d = freeze_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q <= '0;
            en_q  <= '0;
            frz_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            en_q  <= en_d;
            frz_q <= frz_d;
        end
    end

    assign inc_s = inc_q;
    assign en_s  = en_q;
    assign frz_s = frz_q;
`else
    assign inc_s = inc_i;
    assign en_s  = en_mask_i;
    assign frz_s = freeze_i;
`endif

    logic [IncW-1:0] eff_inc [NrEvents];
    logic [AccW-1:0] acc_d   [NrEvents];
    logic [AccW-1:0] acc_q   [NrEvents];
    logic [NrEvents-1:0] ovf_d, ovf_q;
    logic valid_d, valid_q;
    logic fire;
    logic [AccW:0] sum;

    // Event 0 is the reserved "none" ID and never counts.
    always_comb begin
        for (int e = 0; e < NrEvents; e++) begin
            if (frz_s || !en_s[e] || e == 0) begin
                eff_inc[e] = '0;
            end else begin
                eff_inc[e] = inc_s[e*IncW +: IncW];
            end
        end
    end

    always_comb begin
        fire    = valid_q & delta_ready_i;
        ovf_d   = ovf_clr_i ? '0 : ovf_q;
        valid_d = 1'b0;
        sum     = '0;
        for (int e = 0; e < NrEvents; e++) begin
            sum = {1'b0, acc_q[e]} + {{(AccW+1-IncW){1'b0}}, eff_inc[e]};
            if (fire) begin
                // Snapshot leaves; this cycle's increment opens the new window.
                acc_d[e] = {{(AccW-IncW){1'b0}}, eff_inc[e]};
            end else if (sum[AccW]) begin
                acc_d[e] = '1;
                ovf_d[e] = 1'b1;
            end else begin
                acc_d[e] = sum[AccW-1:0];
            end
            valid_d = valid_d | (acc_d[e] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < NrEvents; e++) begin
                acc_q[e] <= '0;
            end
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int e = 0; e < NrEvents; e++) begin
            delta_o[e*AccW +: AccW] = acc_q[e];
        end
    end

    assign delta_valid_o = valid_q;
    assign ovf_o         = ovf_q;

endmodule
